// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with registered reads, write-to-read
// bypass, optional hardwired-zero entry 0 and a one-entry-per-cycle clear sweep.
module regfile_2r1w #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [AW-1:0]    rAddrA,
  input  logic [AW-1:0]    rAddrB,
  input  logic             rEnA,
  input  logic             rEnB,
  output logic [WIDTH-1:0] rDataA,
  output logic [WIDTH-1:0] rDataB,
  input  logic [AW-1:0]    wAddr,
  input  logic [WIDTH-1:0] wData,
  input  logic             writeEn,
  input  logic             clrReq,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e           state_q;
  logic [AW:0]      cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_en;
  logic [WIDTH-1:0] rd_a_d;
  logic [WIDTH-1:0] rd_b_d;

  // Writes are dropped during a sweep and, with ZERO_REG, to entry 0.
  always_comb begin
    wr_en = writeEn && !busy_q;
    if (ZERO_REG && (wAddr == '0)) wr_en = 1'b0;
  end

  // Read mux: new write data wins, then sweep and zero-entry force to 0.
  always_comb begin
    rd_a_d = mem_q[rAddrA];
    if (wr_en && (wAddr == rAddrA)) rd_a_d = wData;
    if (busy_q || (ZERO_REG && (rAddrA == '0))) rd_a_d = '0;
  end

  always_comb begin
    rd_b_d = mem_q[rAddrB];
    if (wr_en && (wAddr == rAddrB)) rd_b_d = wData;
    if (busy_q || (ZERO_REG && (rAddrB == '0))) rd_b_d = '0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rDataA <= '0;
      rDataB <= '0;
    end else begin
      if (rEnA) rDataA <= rd_a_d;
      if (rEnB) rDataB <= rd_b_d;
    end
  end

  // Clear FSM; the counter is one bit wider than the address so it can reach DEPTH.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clrReq) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + (AW+1)'(1);
          if (cnt_q == (AW+1)'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (busy_q && (cnt_q[AW-1:0] == AW'(i))) begin
          mem_q[i] <= '0;
        end else if (wr_en && (wAddr == AW'(i))) begin
          mem_q[i] <= wData;
        end
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: a 32x32 ZERO_REG instance checked against a
// behavioural model, plus an 8x4 instance without the zero entry.
module tb_regfile_2r1w;

  logic        clk;
  logic        clk_run;
  logic        rstN;

  logic [4:0]  rAddrA, rAddrB, wAddr;
  logic        rEnA, rEnB, writeEn, clrReq;
  logic [31:0] rDataA, rDataB, wData;
  logic        busy;

  logic [1:0]  s_rAddrA, s_rAddrB, s_wAddr;
  logic        s_rEnA, s_rEnB, s_writeEn, s_clrReq;
  logic [7:0]  s_rDataA, s_rDataB, s_wData;
  logic        s_busy;

  regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rstN(rstN),
    .rAddrA(rAddrA), .rAddrB(rAddrB), .rEnA(rEnA), .rEnB(rEnB),
    .rDataA(rDataA), .rDataB(rDataB),
    .wAddr(wAddr), .wData(wData), .writeEn(writeEn),
    .clrReq(clrReq), .busy(busy)
  );

  regfile_2r1w #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1'b0)) dut_s (
    .clk(clk), .rstN(rstN),
    .rAddrA(s_rAddrA), .rAddrB(s_rAddrB), .rEnA(s_rEnA), .rEnB(s_rEnB),
    .rDataA(s_rDataA), .rDataB(s_rDataB),
    .wAddr(s_wAddr), .wData(s_wData), .writeEn(s_writeEn),
    .clrReq(s_clrReq), .busy(s_busy)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  // Behavioural model of the 32-entry instance.
  logic [31:0] mdl_mem [32];
  logic [31:0] mdl_a, mdl_b;
  logic        mdl_busy;
  int          mdl_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return rDataA;
      1:       return rDataB;
      2:       return 32'(busy);
      3:       return 32'(s_rDataA);
      4:       return 32'(s_rDataB);
      default: return 32'(s_busy);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  function automatic logic [31:0] mdl_read(input int a, input logic we, input int wa,
                                           input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && (wa == a)) return wd;
    return mdl_mem[a];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl_mem[i] = 32'h0;
    mdl_a    = 32'h0;
    mdl_b    = 32'h0;
    mdl_busy = 1'b0;
    mdl_cnt  = 0;
  endtask

  // One clock of the main instance: drive, predict, push, clock, compare.
  task automatic step(input string tag, input logic we, input int wa, input logic [31:0] wd,
                      input logic ea, input int aa, input logic eb, input int ab,
                      input logic clr);
    writeEn = we;  wAddr  = 5'(wa); wData = wd;
    rEnA    = ea;  rAddrA = 5'(aa);
    rEnB    = eb;  rAddrB = 5'(ab);
    clrReq  = clr;
    if (mdl_busy) begin
      if (ea) mdl_a = 32'h0;
      if (eb) mdl_b = 32'h0;
      mdl_mem[mdl_cnt] = 32'h0;
      mdl_cnt++;
      if (mdl_cnt == 32) mdl_busy = 1'b0;
    end else begin
      if (ea) mdl_a = mdl_read(aa, we, wa, wd);
      if (eb) mdl_b = mdl_read(ab, we, wa, wd);
      if (we && (wa != 0)) mdl_mem[wa] = wd;
      if (clr) begin
        mdl_busy = 1'b1;
        mdl_cnt  = 0;
      end
    end
    push({tag, "_a"}, 0, mdl_a);
    push({tag, "_b"}, 1, mdl_b);
    push({tag, "_busy"}, 2, 32'(mdl_busy));
    tick();
    writeEn = 1'b0; rEnA = 1'b0; rEnB = 1'b0; clrReq = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    clk_run = 1'b0;
    #3;
    rstN = 1'b0;
    #1;
    mdl_reset();
    push({tag, "_a"}, 0, 32'h0);
    push({tag, "_b"}, 1, 32'h0);
    push({tag, "_busy"}, 2, 32'h0);
    push({tag, "_sbusy"}, 5, 32'h0);
    drain();
    #3;
    rstN = 1'b1;
    #2;
    clk_run = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    clk_run = 1'b0;
    rstN    = 1'b1;
    {rAddrA, rAddrB, wAddr, wData} = '0;
    {rEnA, rEnB, writeEn, clrReq}  = '0;
    {s_rAddrA, s_rAddrB, s_wAddr, s_wData} = '0;
    {s_rEnA, s_rEnB, s_writeEn, s_clrReq}  = '0;
    mdl_reset();
    #2;
    async_reset("rst");

    // All entries read 0 after reset.
    for (int i = 1; i < 32; i++) step("rst_rd", 1'b0, 0, 0, 1'b1, i, 1'b1, 32 - i, 1'b0);

    // Write/read, then hold with rEnA low.
    step("wr5", 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 0, 1'b0);
    step("rd5", 1'b0, 0, 0, 1'b1, 5, 1'b0, 0, 1'b0);
    step("hold5", 1'b0, 0, 0, 1'b0, 9, 1'b0, 0, 1'b0);

    // Bypass on entry 7 and on the hardwired zero entry.
    step("wr7", 1'b1, 7, 32'h11, 1'b0, 0, 1'b0, 0, 1'b0);
    step("byp7", 1'b1, 7, 32'h22, 1'b1, 7, 1'b1, 7, 1'b0);
    step("rd7", 1'b0, 0, 0, 1'b1, 7, 1'b1, 5, 1'b0);
    step("byp0", 1'b1, 0, 32'h33, 1'b1, 0, 1'b1, 0, 1'b0);
    step("rd0", 1'b0, 0, 0, 1'b1, 0, 1'b1, 0, 1'b0);

    // Fill with addr+1, then a clear that coincides with a write and a bypassed read.
    for (int i = 0; i < 32; i++) step("fill", 1'b1, i, 32'(i + 1), 1'b0, 0, 1'b0, 0, 1'b0);
    step("pre", 1'b0, 0, 0, 1'b1, 3, 1'b1, 31, 1'b0);
    step("clr", 1'b1, 9, 32'h99, 1'b0, 0, 1'b1, 9, 1'b1);
    for (int j = 0; j < 32; j++)
      step("sweep", 1'b1, (j + 1) % 32, 32'hBAD0 + 32'(j), 1'b0, 0, (j % 4) == 1, 2,
           (j == 5) || (j == 31));
    step("post_wr", 1'b1, 12, 32'h1234, 1'b0, 0, 1'b0, 0, 1'b0);
    for (int i = 1; i < 32; i++) step("post_rd", 1'b0, 0, 0, 1'b1, i, 1'b1, i, 1'b0);

    // Reset in the middle of a sweep; a new sweep then runs the full length.
    step("wr4", 1'b1, 4, 32'h44, 1'b0, 0, 1'b0, 0, 1'b0);
    step("rd4", 1'b0, 0, 0, 1'b1, 4, 1'b1, 4, 1'b0);
    step("clr2", 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int j = 0; j < 10; j++) step("sweep2", 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    async_reset("midrst");
    step("rd4r", 1'b0, 0, 0, 1'b1, 4, 1'b0, 0, 1'b0);
    step("wr30", 1'b1, 30, 32'h3030, 1'b0, 0, 1'b0, 0, 1'b0);
    step("clr3", 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int j = 0; j < 32; j++) step("sweep3", 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    step("rd30", 1'b0, 0, 0, 1'b1, 30, 1'b0, 0, 1'b0);

    // 8x4 instance without the zero entry.
    s_writeEn = 1'b1; s_wAddr = 2'd0; s_wData = 8'hA5;
    push("s_wr0", 5, 32'h0);
    tick();
    s_writeEn = 1'b0;
    s_rEnA = 1'b1; s_rAddrA = 2'd0;
    push("s_rd0", 3, 32'hA5);
    tick();
    s_writeEn = 1'b1; s_wAddr = 2'd2; s_wData = 8'h5A;
    s_rAddrA = 2'd2; s_rEnB = 1'b1; s_rAddrB = 2'd2;
    push("s_byp2a", 3, 32'h5A);
    push("s_byp2b", 4, 32'h5A);
    tick();
    s_writeEn = 1'b0; s_rEnA = 1'b0; s_rEnB = 1'b0;
    s_clrReq = 1'b1;
    push("s_clr", 5, 32'h1);
    tick();
    s_clrReq = 1'b0;
    for (int j = 0; j < 3; j++) begin
      push("s_sweep", 5, 32'h1);
      tick();
    end
    push("s_sweep_end", 5, 32'h0);
    tick();
    s_rEnA = 1'b1; s_rAddrA = 2'd0; s_rEnB = 1'b1; s_rAddrB = 2'd2;
    push("s_post0", 3, 32'h0);
    push("s_post2", 4, 32'h0);
    tick();
    s_rEnA = 1'b0; s_rEnB = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file: the next generation of the datapath's 32x32 register file, configurable in width and depth. It has two registered read ports, one write port and write-to-read bypass. An optional hardwired-zero entry 0 is available. A sequential clear engine sweeps the array one entry per cycle. It sits between decode (read addresses) and writeback (write port) in the core.

## Interface
- `WIDTH`, default 32, data width in bits.
- `DEPTH`, default 32, number of entries; power of two, ≥ 2.
- `AW`, default $clog2(DEPTH), address width; derived, not overridden.
- `ZERO_REG`, default 1. When 1, entry 0 always reads 0 and writes to it are dropped.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstN`  in  1  reset; asynchronous, active-low.
- `rAddrA`, `rAddrB`  in  AW  read addresses.
- `rEnA`, `rEnB`  in  1  read enables. When low, the corresponding output holds its value.
- `rDataA`, `rDataB`  out  WIDTH  registered read data.
- `wAddr`  in  AW  write address.
- `wData`  in  WIDTH  write data.
- `writeEn`  in  1  write enable.
- `clrReq`  in  1  single-cycle pulse that starts a clear sweep.
- `busy`  out  1  high while a clear sweep is in progress.

## Operation
- Storage is DEPTH x WIDTH flops. While `rstN` is low, every entry, `rDataA`, `rDataB`, `busy` and the clear counter are 0, and the FSM is in IDLE.
- Read: on an edge with `rEnX`=1, `rDataX` loads the value of entry `rAddrX`.
- Bypass: if `writeEn`=1 and `wAddr`==`rAddrX` at the same edge, `rDataX` loads `wData`, not the old value. This is the new-data-wins rule.
- `ZERO_REG`=1:
  - A read of address 0 returns 0, including when bypass would otherwise apply.
  - A write to address 0 has no effect.
- Both read ports may use the same address, including the bypassed address. They then return identical data.
- Clear FSM, two states:
  - IDLE: `clrReq`=1 at an edge moves to CLEAR with counter = 0. `busy` rises after that edge.
  - CLEAR: each edge writes 0 to entry[counter] and increments counter. At the edge that clears entry DEPTH-1, the FSM returns to IDLE and `busy` falls.
- While `busy`=1:
  - `writeEn` is ignored; writes are dropped, not queued.
  - Enabled reads load 0.
  - `clrReq` is ignored.
- `clrReq` and `writeEn` at the same IDLE edge: the write is performed, then the sweep overwrites it.
- `rstN` falling mid-sweep: immediate return to the full reset state above. The sweep does not resume.
- Address arithmetic:
  - The counter is AW+1 bits, so it terminates cleanly when DEPTH = 2^AW.
  - Addresses are always in range, since DEPTH is a power of two.

## Timing
- Read latency 1 cycle: address presented before edge k gives data valid after edge k.
- Write visible to a same-address read at the same edge through bypass, and to all later reads.
- Clear sweep:
  - Starts when `clrReq` is sampled at edge k.
  - `busy` is high from after edge k through edge k+DEPTH, inclusive.
  - The first accepted write is at edge k+DEPTH+1.
- Reset is asynchronous: outputs go to 0 without a clock edge. Release is synchronised externally.

## Test plan
- Reset: drive `rstN`=0 mid-cycle with the clock stopped. `rDataA`=`rDataB`=0 and `busy`=0 immediately. After release, reads of addresses 1..DEPTH-1 return 0.
- Write/read: write 0xDEADBEEF to entry 5, then read `rAddrA`=5 → 0xDEADBEEF one cycle later. With `rEnA`=0 the next cycle, `rDataA` holds 0xDEADBEEF.
- Bypass: entry 7 holds 0x11. Same edge: write 0x22 to 7 and read 7 on both ports → both return 0x22. Repeat on address 0 with `ZERO_REG`=1 → both return 0.
- Clear sweep, DEPTH=32:
  - Fill all entries with `addr+1`, then pulse `clrReq`.
  - `busy` is high for exactly 32 cycles.
  - Writes and `clrReq` during `busy` are dropped.
  - Afterwards all entries read 0.
  - A write at the first cycle after `busy` falls succeeds.
- Reset mid-sweep: assert `rstN`=0 at sweep cycle 10 → `busy`=0 immediately. After release, the FSM is IDLE and a new `clrReq` starts from entry 0.
- Parameter sweep: WIDTH=8, DEPTH=4, `ZERO_REG`=0. A write of 0xA5 to entry 0 reads back 0xA5. The sweep lasts 4 cycles.
